// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - hold levels, FSM state encoding and bus widths for pipe_ctrl
package pipe_ctrl_pkg;

  localparam int HOLD_W = 3;
  localparam int ADDR_W = 32;
  localparam int STALL_W = 8;
  localparam int FLUSH_W = 3;

  // A stage register loads NOP when the hold level is >= its own level.
  typedef enum logic [HOLD_W-1:0] {
    HOLD_NONE  = 3'd0,
    HOLD_PC    = 3'd1,
    HOLD_IF_ID = 3'd2,
    HOLD_ID_EX = 3'd3
  } hold_e;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_DIV_WAIT = 2'd2,
    ST_MEM_WAIT = 2'd3
  } state_e;

endpackage

// File: rtl/pipe_ctrl_if.sv
// rtl/pipe_ctrl_if.sv - pipeline-side request/redirect bus of pipe_ctrl
interface pipe_ctrl_if;
  import pipe_ctrl_pkg::*;

  logic              jump_req_i;
  logic [ADDR_W-1:0] jump_addr_i;
  logic              irq_req_i;
  logic [ADDR_W-1:0] irq_addr_i;
  logic              div_busy_i;
  logic              mem_busy_i;
  logic [ADDR_W-1:0] replay_addr_i;
  logic [HOLD_W-1:0] hold_flag_o;
  logic              jump_flag_o;
  logic [ADDR_W-1:0] jump_addr_o;
  logic              irq_ack_o;
  logic [ADDR_W-1:0] irq_epc_o;
  logic              stall_err_o;

  modport master (
    output jump_req_i, jump_addr_i, irq_req_i, irq_addr_i,
           div_busy_i, mem_busy_i, replay_addr_i,
    input  hold_flag_o, jump_flag_o, jump_addr_o, irq_ack_o, irq_epc_o, stall_err_o
  );

  modport slave (
    input  jump_req_i, jump_addr_i, irq_req_i, irq_addr_i,
           div_busy_i, mem_busy_i, replay_addr_i,
    output hold_flag_o, jump_flag_o, jump_addr_o, irq_ack_o, irq_epc_o, stall_err_o
  );

endinterface

// File: rtl/pipe_ctrl_stall_wdt.sv
// rtl/pipe_ctrl_stall_wdt.sv - consecutive wait-state counter with limit detect
module pipe_ctrl_stall_wdt
  import pipe_ctrl_pkg::*;
#(
  parameter int STALL_LIMIT = 255
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic start_i,
  input  logic inc_i,
  input  logic clr_i,
  output logic expired_o
);

  logic [STALL_W-1:0] cnt_q;

  // rst_n_i is active-high despite its name.
  always_ff @(posedge clk_i) begin
    if (rst_n_i || clr_i) begin
      cnt_q <= '0;
    end else if (start_i) begin
      cnt_q <= STALL_W'(1);
    end else if (inc_i) begin
      cnt_q <= cnt_q + STALL_W'(1);
    end
  end

  assign expired_o = (cnt_q == STALL_W'(STALL_LIMIT));

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline hold/flush/redirect controller with interrupt
// deferral across multi-cycle stalls and a stall watchdog
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int STALL_LIMIT  = 255
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  pipe_ctrl_if.slave bus
);

  state_e             state_q, state_d;
  logic [FLUSH_W-1:0] flush_q, flush_d;
  logic [ADDR_W-1:0]  replay_q, replay_d;
  logic               err_q, err_d;
  logic               wdt_start, wdt_inc, wdt_clr, wdt_expired;
  logic               busy_w;
  hold_e              hold;
  logic               jump_flag;
  logic [ADDR_W-1:0]  jump_addr;
  logic               irq_ack;
  logic [ADDR_W-1:0]  irq_epc;

  pipe_ctrl_stall_wdt #(.STALL_LIMIT(STALL_LIMIT)) u_wdt (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .start_i   (wdt_start),
    .inc_i     (wdt_inc),
    .clr_i     (wdt_clr),
    .expired_o (wdt_expired)
  );

  always_comb begin
    state_d   = state_q;
    flush_d   = flush_q;
    replay_d  = replay_q;
    err_d     = err_q;
    wdt_start = 1'b0;
    wdt_inc   = 1'b0;
    wdt_clr   = 1'b0;
    hold      = HOLD_NONE;
    jump_flag = 1'b0;
    jump_addr = '0;
    irq_ack   = 1'b0;
    irq_epc   = '0;
    busy_w    = (state_q == ST_DIV_WAIT) ? bus.div_busy_i : bus.mem_busy_i;

    case (state_q)
      ST_RUN: begin
        if (bus.jump_req_i) begin
          hold      = HOLD_ID_EX;
          jump_flag = 1'b1;
          jump_addr = bus.jump_addr_i;
          state_d   = ST_FLUSH;
          flush_d   = FLUSH_W'(FLUSH_CYCLES);
        end else if (bus.div_busy_i || bus.mem_busy_i) begin
          // A pending interrupt waits here; it is re-evaluated on busy release.
          hold      = HOLD_ID_EX;
          replay_d  = bus.replay_addr_i;
          wdt_start = 1'b1;
          state_d   = bus.div_busy_i ? ST_DIV_WAIT : ST_MEM_WAIT;
        end else if (bus.irq_req_i) begin
          hold      = HOLD_ID_EX;
          jump_flag = 1'b1;
          jump_addr = bus.irq_addr_i;
          irq_ack   = 1'b1;
          irq_epc   = bus.replay_addr_i;
          state_d   = ST_FLUSH;
          flush_d   = FLUSH_W'(FLUSH_CYCLES);
        end
      end
      ST_FLUSH: begin
        hold = HOLD_ID_EX;
        if (flush_q <= FLUSH_W'(1)) begin
          state_d = ST_RUN;
        end else begin
          flush_d = flush_q - FLUSH_W'(1);
        end
      end
      ST_DIV_WAIT, ST_MEM_WAIT: begin
        hold = HOLD_ID_EX;
        if (busy_w && !wdt_expired) begin
          wdt_inc = 1'b1;
        end else begin
          jump_flag = 1'b1;
          jump_addr = replay_q;
          wdt_clr   = 1'b1;
          state_d   = ST_FLUSH;
          flush_d   = FLUSH_W'(FLUSH_CYCLES);
          if (busy_w) begin
            err_d = 1'b1;
          end else if (bus.irq_req_i) begin
            jump_addr = bus.irq_addr_i;
            irq_ack   = 1'b1;
            irq_epc   = replay_q;
          end
        end
      end
      default: state_d = ST_RUN;
    endcase

    if (rst_n_i) begin
      hold      = HOLD_ID_EX;
      jump_flag = 1'b0;
      jump_addr = '0;
      irq_ack   = 1'b0;
      irq_epc   = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_n_i) begin
      state_q  <= ST_RUN;
      flush_q  <= '0;
      replay_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      flush_q  <= flush_d;
      replay_q <= replay_d;
      err_q    <= err_d;
    end
  end

  assign bus.hold_flag_o = hold;
  assign bus.jump_flag_o = jump_flag;
  assign bus.jump_addr_o = jump_addr;
  assign bus.irq_ack_o   = irq_ack;
  assign bus.irq_epc_o   = irq_epc;
  assign bus.stall_err_o = err_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed scoreboard bench for pipe_ctrl
module tb_pipe_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  pipe_ctrl_if ifd ();
  pipe_ctrl_if ifw ();

  pipe_ctrl #(.FLUSH_CYCLES(2), .STALL_LIMIT(255)) dut (
    .clk_i(clk), .rst_n_i(rst), .bus(ifd.slave)
  );

  pipe_ctrl #(.FLUSH_CYCLES(2), .STALL_LIMIT(4)) dut_wd (
    .clk_i(clk), .rst_n_i(rst), .bus(ifw.slave)
  );

  typedef struct {
    string       tag;
    bit          wd;
    logic [2:0]  hold;
    logic        jf;
    logic [31:0] ja;
    logic        ack;
    logic [31:0] epc;
    logic        err;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string tag, input string f, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s.%s observed=%h expected=%h", tag, f, o, e);
    end
  endtask

  task automatic drv(input logic r, input logic j, input logic [31:0] ja, input logic irq,
                     input logic [31:0] ia, input logic dv, input logic mb, input logic [31:0] ra);
    rst = r;
    ifd.jump_req_i = j;  ifd.jump_addr_i = ja; ifd.irq_req_i = irq; ifd.irq_addr_i = ia;
    ifd.div_busy_i = dv; ifd.mem_busy_i = mb;  ifd.replay_addr_i = ra;
    ifw.jump_req_i = j;  ifw.jump_addr_i = ja; ifw.irq_req_i = irq; ifw.irq_addr_i = ia;
    ifw.div_busy_i = dv; ifw.mem_busy_i = mb;  ifw.replay_addr_i = ra;
  endtask

  task automatic expect_out(input string tag, input bit wd, input logic [2:0] hold, input logic jf,
                            input logic [31:0] ja, input logic ack, input logic [31:0] epc,
                            input logic err);
    exp_t e;
    e.tag = tag; e.wd = wd; e.hold = hold; e.jf = jf; e.ja = ja;
    e.ack = ack; e.epc = epc; e.err = err;
    sb.push_back(e);
  endtask

  // Outputs are sampled on the falling edge, mid-cycle after inputs settle.
  task automatic tick();
    exp_t e;
    logic [2:0]  o_hold;
    logic        o_jf, o_ack, o_err;
    logic [31:0] o_ja, o_epc;
    @(negedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.wd) begin
        o_hold = ifw.hold_flag_o; o_jf = ifw.jump_flag_o; o_ja = ifw.jump_addr_o;
        o_ack = ifw.irq_ack_o; o_epc = ifw.irq_epc_o; o_err = ifw.stall_err_o;
      end else begin
        o_hold = ifd.hold_flag_o; o_jf = ifd.jump_flag_o; o_ja = ifd.jump_addr_o;
        o_ack = ifd.irq_ack_o; o_epc = ifd.irq_epc_o; o_err = ifd.stall_err_o;
      end
      chk(e.tag, "hold", 32'(o_hold), 32'(e.hold));
      chk(e.tag, "jump_flag", 32'(o_jf), 32'(e.jf));
      chk(e.tag, "jump_addr", o_ja, e.ja);
      chk(e.tag, "irq_ack", 32'(o_ack), 32'(e.ack));
      chk(e.tag, "irq_epc", o_epc, e.epc);
      chk(e.tag, "stall_err", 32'(o_err), 32'(e.err));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    drv(1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    expect_out("reset", 0, 3, 0, 0, 0, 0, 0); tick();
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    expect_out("idle", 0, 0, 0, 0, 0, 0, 0); tick();

    drv(0, 1, 32'h100, 0, 0, 0, 0, 0);
    expect_out("jump", 0, 3, 1, 32'h100, 0, 0, 0); tick();
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    expect_out("jump_flush1", 0, 3, 0, 0, 0, 0, 0); tick();
    expect_out("jump_flush2", 0, 3, 0, 0, 0, 0, 0); tick();
    expect_out("jump_run", 0, 0, 0, 0, 0, 0, 0); tick();

    drv(0, 0, 0, 0, 0, 1, 0, 32'h40);
    expect_out("div_entry", 0, 3, 0, 0, 0, 0, 0); tick();
    for (int i = 0; i < 4; i++) begin
      drv(0, 0, 0, 0, 0, 1, 0, 32'h44 + 32'(4 * i));
      expect_out("div_wait", 0, 3, 0, 0, 0, 0, 0); tick();
    end
    drv(0, 0, 0, 0, 0, 0, 0, 32'h99);
    expect_out("div_release", 0, 3, 1, 32'h40, 0, 0, 0); tick();
    expect_out("div_flush1", 0, 3, 0, 0, 0, 0, 0); tick();
    expect_out("div_flush2", 0, 3, 0, 0, 0, 0, 0); tick();
    expect_out("div_run", 0, 0, 0, 0, 0, 0, 0); tick();

    drv(0, 0, 0, 1, 32'h80, 0, 0, 32'h24);
    expect_out("irq_take", 0, 3, 1, 32'h80, 1, 32'h24, 0); tick();
    expect_out("irq_flush1", 0, 3, 0, 0, 0, 0, 0); tick();
    expect_out("irq_flush2", 0, 3, 0, 0, 0, 0, 0); tick();
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    expect_out("irq_run", 0, 0, 0, 0, 0, 0, 0); tick();

    drv(0, 0, 0, 1, 32'h88, 0, 1, 32'h30);
    expect_out("mem_irq_entry", 0, 3, 0, 0, 0, 0, 0); tick();
    drv(0, 0, 0, 1, 32'h88, 0, 1, 32'h50);
    expect_out("mem_irq_wait", 0, 3, 0, 0, 0, 0, 0); tick();
    drv(0, 0, 0, 1, 32'h88, 0, 0, 32'h50);
    expect_out("mem_irq_release", 0, 3, 1, 32'h88, 1, 32'h30, 0); tick();
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    expect_out("mem_irq_flush1", 0, 3, 0, 0, 0, 0, 0); tick();
    expect_out("mem_irq_flush2", 0, 3, 0, 0, 0, 0, 0); tick();

    drv(0, 0, 0, 1, 32'h88, 1, 0, 32'h60);
    expect_out("irq_drop_entry", 0, 3, 0, 0, 0, 0, 0); tick();
    drv(0, 0, 0, 0, 32'h88, 0, 0, 0);
    expect_out("irq_drop_release", 0, 3, 1, 32'h60, 0, 0, 0); tick();
    expect_out("irq_drop_flush1", 0, 3, 0, 0, 0, 0, 0); tick();
    expect_out("irq_drop_flush2", 0, 3, 0, 0, 0, 0, 0); tick();

    drv(0, 1, 32'h200, 1, 32'h80, 0, 0, 32'h10);
    expect_out("jump_over_irq", 0, 3, 1, 32'h200, 0, 0, 0); tick();
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    expect_out("jirq_flush1", 0, 3, 0, 0, 0, 0, 0); tick();
    drv(1, 0, 0, 0, 0, 0, 0, 0);
    expect_out("rst_mid_flush", 0, 3, 0, 0, 0, 0, 0); tick();
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    expect_out("after_rst_flush", 0, 0, 0, 0, 0, 0, 0); tick();

    drv(0, 0, 0, 1, 32'h90, 1, 0, 32'h70);
    expect_out("rw_entry", 0, 3, 0, 0, 0, 0, 0); tick();
    expect_out("rw_wait", 0, 3, 0, 0, 0, 0, 0); tick();
    drv(1, 0, 0, 1, 32'h90, 1, 0, 32'h70);
    expect_out("rst_mid_wait", 0, 3, 0, 0, 0, 0, 0); tick();
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    expect_out("after_rst_wait", 0, 0, 0, 0, 0, 0, 0); tick();

    drv(1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    drv(0, 0, 0, 0, 0, 1, 0, 32'h34);
    expect_out("wd_entry", 1, 3, 0, 0, 0, 0, 0); tick();
    for (int i = 0; i < 3; i++) begin
      expect_out("wd_wait", 1, 3, 0, 0, 0, 0, 0); tick();
    end
    expect_out("wd_fire", 1, 3, 1, 32'h34, 0, 0, 0); tick();
    expect_out("wd_flush1", 1, 3, 0, 0, 0, 0, 1); tick();
    expect_out("wd_flush2", 1, 3, 0, 0, 0, 0, 1); tick();
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      expect_out("wd_sticky", 1, 0, 0, 0, 0, 0, 1); tick();
    end
    drv(1, 0, 0, 0, 0, 0, 0, 0);
    expect_out("wd_rst", 1, 3, 0, 0, 0, 0, 1); tick();
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    expect_out("wd_cleared", 1, 0, 0, 0, 0, 0, 0); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
